seq_pattern_tx: RTL

Serial pattern transmitter: the driving end of the FSM serial-bit interface used by the sequence detectors. It accepts a parallel pattern and a repeat count on a `start` pulse and shifts the pattern out MSB-first, one bit per clock, for `repeat_n + 1` back-to-back passes. It also counts overlapping `101` occurrences in the emitted stream, so a bench can compare a detector's `y` pulses against an expected hit count.

---
 rtl/seq_pattern_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first for
// repeat_n+1 back-to-back passes and counts overlapping 101 occurrences.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hits
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [WIDTH-1:0] sreg_q, sreg_n;
  logic [CNT_W-1:0] pass_q, pass_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [1:0]       hist_q, hist_n;
  logic             dout_n, valid_n, busy_n, done_n;
  logic [HIT_W-1:0] hits_n;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + HIT_W'(1);
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    sreg_n  = sreg_q;
    pass_n  = pass_q;
    idx_n   = idx_q;
    hist_n  = hist_q;
    dout_n  = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    hits_n  = hits;

    case (state)
      IDLE: begin
        if (start) begin
          pat_n   = pattern;
          sreg_n  = rotl(pattern);
          pass_n  = repeat_n;
          idx_n   = '0;
          hist_n  = 2'b00;
          hits_n  = '0;
          dout_n  = pattern[WIDTH-1];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        // The bit currently on dout is being retired at this edge.
        hist_n = {hist_q[0], dout};
        if (dout && (hist_q == 2'b10)) begin
          hits_n = sat_inc(hits);
        end

        if (idx_q == LAST_IDX) begin
          if (pass_q != '0) begin
            pass_n  = pass_q - CNT_W'(1);
            sreg_n  = rotl(pat_q);
            dout_n  = pat_q[WIDTH-1];
            valid_n = 1'b1;
            busy_n  = 1'b1;
            idx_n   = '0;
          end else begin
            done_n  = 1'b1;
            state_n = DONE;
          end
        end else begin
          dout_n  = sreg_q[WIDTH-1];
          sreg_n  = rotl(sreg_q);
          valid_n = 1'b1;
          busy_n  = 1'b1;
          idx_n   = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control and visible outputs: reset aborts any transmission silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dout  <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hits  <= '0;
    end else begin
      state <= state_n;
      dout  <= dout_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
      hits  <= hits_n;
    end
  end

  // Datapath registers; always reinitialised by an accepted start.
  always_ff @(posedge clk) begin
    pat_q  <= pat_n;
    sreg_q <= sreg_n;
    pass_q <= pass_n;
    idx_q  <= idx_n;
    hist_q <= hist_n;
  end

endmodule
